instruction_fetcher: RTL

//  Producer side of the decoder's instruction interface. Walks a program in

---
 rtl/instruction_fetcher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// ---------------------------------------------------------------------------
// instruction_fetcher
//
// Purpose:
//   Front-end producer for the decoder. Starting from start_pc, walks
//   prog_len words of program memory. It issues one read per word over a
//   valid/ready memory port. Each returned word is then handed to the decoder,
//   together with its PC, over a valid/ready handshake. Only one word is in
//   flight at a time, so the best case is one instruction every two cycles.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              begin a program (sampled only while idle)
//   start_pc           first address, sampled with start
//   prog_len           number of words to fetch, sampled with start
//   abort              cancel the running program (no done pulse)
//   mem_read_valid     read request towards program memory
//   mem_read_address   read address, always equal to the internal pc
//   mem_read_ready     memory returns mem_read_data this cycle
//   mem_read_data      memory read data
//   inst_valid         word presented to the decoder
//   instruction        presented word
//   inst_pc            address of the presented word
//   inst_ready         decoder accepts the presented word
//   busy               fetcher is not idle
//   done               one-cycle pulse when the whole program was delivered
// ---------------------------------------------------------------------------
module instruction_fetcher #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic [LEN_WIDTH-1:0]  prog_len,
    input  logic                  abort,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [INST_WIDTH-1:0] mem_read_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [LEN_WIDTH-1:0]  remaining;

    // State register. Reset wins over every other input, including abort
    // and start, so a mid-program reset never produces a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. abort takes priority over start and over any
    // handshake that completes in the same cycle, so such a word is dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = (prog_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (mem_read_ready) begin
                    next_state = DELIVER;
                end
            end
            DELIVER: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (inst_ready) begin
                    next_state = (remaining == LEN_WIDTH'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake and status outputs are decoded purely from the state
    // register, so they are glitch-free and carry no input-to-output path.
    always_comb begin
        mem_read_valid = 1'b0;
        inst_valid     = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state)
            IDLE:    busy           = 1'b0;
            FETCH:   mem_read_valid = 1'b1;
            DELIVER: inst_valid     = 1'b1;
            DONE:    done           = 1'b1;
            default: busy           = 1'b0;
        endcase
    end

    // The read address is the pc register itself. pc only moves when the
    // decoder accepts a word, so the address stays put for the whole read.
    assign mem_read_address = pc;

    // Datapath. pc and remaining load on start. The presented word and its
    // PC are captured on the memory handshake and held until the next
    // capture. pc advances (wrapping naturally) only on a decoder handshake
    // that is not cancelled by abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            remaining   <= '0;
            instruction <= '0;
            inst_pc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        pc        <= start_pc;
                        remaining <= prog_len;
                    end
                end
                FETCH: begin
                    if (!abort && mem_read_ready) begin
                        instruction <= mem_read_data;
                        inst_pc     <= pc;
                    end
                end
                DELIVER: begin
                    if (!abort && inst_ready) begin
                        pc        <= pc + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
